multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-style control FSM: fetch/decode/execute/memory/writeback
// with illegal-opcode and memory-timeout traps.
module multicycle_controller #(
  parameter bit ENABLE_BRANCH = 1'b1,
  parameter bit ENABLE_UPPER  = 1'b1,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       branch_taken,
  input  logic       mem_ready,
  input  logic       trap_clear,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] reg_src,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       fault,
  output logic [1:0] fault_cause,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t        r_state;
  logic [1:0]    r_cause;
  logic [CW-1:0] r_wait;

  logic          w_load, w_store, w_opimm, w_op, w_jump, w_branch, w_lui, w_auipc;
  logic          w_legal, w_timeout;
  logic [CW-1:0] w_wait_inc;

  assign w_load   = (op == OP_LOAD);
  assign w_store  = (op == OP_STORE);
  assign w_opimm  = (op == OP_OPIMM);
  assign w_op     = (op == OP_OP);
  assign w_jump   = (op == OP_JAL) || (op == OP_JALR);
  assign w_branch = ENABLE_BRANCH && (op == OP_BRANCH);
  assign w_lui    = ENABLE_UPPER && (op == OP_LUI);
  assign w_auipc  = ENABLE_UPPER && (op == OP_AUIPC);
  assign w_legal  = w_load || w_store || w_opimm || w_op || w_jump
                 || w_branch || w_lui || w_auipc;

  // The current waiting cycle counts toward the limit, so a limit of N
  // allows exactly N cycles without an acknowledge.
  assign w_wait_inc = r_wait + CW'(1);
  assign w_timeout  = (MEM_TIMEOUT != 0) && (w_wait_inc == CW'(MEM_TIMEOUT));

  assign state       = r_state;
  assign fault_cause = r_cause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cause <= 2'd0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_wait  <= '0;
        end
        S_FETCH: begin
          if (mem_ready) begin
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_cause <= 2'd2;
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_state <= S_TRAP;
            r_cause <= 2'd1;
          end
        end
        S_EXEC: begin
          r_wait <= '0;
          if (w_load || w_store) r_state <= S_MEM;
          else if (w_branch)     r_state <= S_FETCH;
          else                   r_state <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            r_wait  <= '0;
            r_state <= w_load ? S_WB : S_FETCH;
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_cause <= 2'd2;
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_wait  <= '0;
        end
        S_TRAP: begin
          if (trap_clear) begin
            r_state <= S_FETCH;
            r_cause <= 2'd0;
            r_wait  <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cause <= 2'd0;
          r_wait  <= '0;
        end
      endcase
    end
  end

  // Enables react to mem_ready in the same cycle so a one-cycle acknowledge is never lost.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    reg_we    = 1'b0;
    reg_src   = 2'd0;
    alu_src_b = 1'b0;
    alu_op    = 2'd0;
    retire    = 1'b0;
    fault     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_b = !(w_op || w_branch);
        if (w_op || w_opimm) alu_op = 2'd2;
        else if (w_branch)   alu_op = 2'd1;
        else if (w_lui)      alu_op = 2'd3;
        else                 alu_op = 2'd0;
        if (w_branch) begin
          pc_we  = branch_taken;
          pc_src = 2'd1;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = w_store;
        if (mem_ready) begin
          retire = w_store;
          mdr_we = w_load;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        retire = 1'b1;
        if (w_load)      reg_src = 2'd1;
        else if (w_jump) reg_src = 2'd2;
        else             reg_src = 2'd0;
        if (w_jump) begin
          pc_we  = 1'b1;
          pc_src = 2'd2;
        end
      end
      S_TRAP: begin
        fault = 1'b1;
      end
      default: begin
        fault = 1'b0;
      end
    endcase
  end

endmodule
